// File: rtl/aer_merger_pkg.sv
// ============================================================================
// aer_merger_pkg : shared types and helpers for the multicore AER event merger
// Revision: 1.0
// ============================================================================
`default_nettype none

package aer_merger_pkg;

  typedef enum logic [0:0] {
    IN_IDLE = 1'b0,
    IN_ACK  = 1'b1
  } in_state_e;

  typedef enum logic [1:0] {
    OUT_IDLE     = 2'd0,
    OUT_REQ      = 2'd1,
    OUT_WAIT_LOW = 2'd2
  } out_state_e;

  localparam int SPECIAL_PREFIX_W = 2;

  // Width of the core_id field prepended to each forwarded address.
  function automatic int core_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic is_special(input logic [SPECIAL_PREFIX_W-1:0] top_bits,
                                      input logic [SPECIAL_PREFIX_W-1:0] prefix);
    return top_bits == prefix;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aer_evt_fifo.sv
// ============================================================================
// aer_evt_fifo : synchronous FIFO with registered full flag and head output
// Revision: 1.0
// ============================================================================
`default_nettype none

module aer_evt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic [AW:0]      cnt_d;
  logic             full_q;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && (!full_q || do_pop);

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + (AW+1)'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_q];
  assign full_o  = full_q;
  assign empty_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/aer_multicore_event_merger.sv
// ============================================================================
// aer_multicore_event_merger : per-core 4-phase AER inputs, round-robin merge
// onto one 4-phase output with core_id prefix and optional special barrier.
// Revision: 1.0
// ============================================================================
`default_nettype none

module aer_multicore_event_merger
  import aer_merger_pkg::*;
#(
  parameter int         CORE_NUM           = 4,
  parameter int         AER_OUT_CORE_WIDTH = 8,
  parameter int         FIFO_DEPTH         = 4,
  parameter logic [1:0] SPECIAL_PREFIX     = 2'b01,
  parameter bit         MERGE_SPECIAL      = 1'b1
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [CORE_NUM-1:0]                              core_req,
  input  logic [CORE_NUM*AER_OUT_CORE_WIDTH-1:0]           core_addr,
  output logic [CORE_NUM-1:0]                              core_ack,
  output logic                                             evt_req,
  output logic [AER_OUT_CORE_WIDTH+$clog2(CORE_NUM)-1:0]   evt_addr,
  input  logic                                             evt_ack,
  output logic [CORE_NUM-1:0]                              fifo_full,
  output logic [CORE_NUM-1:0]                              special_pending
);

  localparam int W   = AER_OUT_CORE_WIDTH;
  localparam int CIW = core_id_w(CORE_NUM);
  localparam int OW  = W + CIW;

  logic [CORE_NUM-1:0] push;
  logic [CORE_NUM-1:0] pop;
  logic [CORE_NUM-1:0] full;
  logic [CORE_NUM-1:0] empty;
  logic [CORE_NUM-1:0] spec_head;
  logic [CORE_NUM-1:0] normal_cand;
  logic [W-1:0]        head [CORE_NUM];

  out_state_e          out_state_q;
  logic                req_q;
  logic [OW-1:0]       addr_q;
  logic [CIW-1:0]      rr_q;
  logic [CIW-1:0]      gnt_q;
  logic                merge_q;

  logic                found;
  logic [CIW-1:0]      sel;
  logic [CIW:0]        idx_w;
  logic                all_special;

  for (genvar i = 0; i < CORE_NUM; i++) begin : g_core
    in_state_e st_q;
    logic      ack_q;

    aer_evt_fifo #(
      .WIDTH (W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push[i]),
      .pop_i   (pop[i]),
      .din_i   (core_addr[i*W +: W]),
      .head_o  (head[i]),
      .full_o  (full[i]),
      .empty_o (empty[i])
    );

    assign spec_head[i]   = MERGE_SPECIAL && !empty[i] &&
                            is_special(head[i][W-1 -: SPECIAL_PREFIX_W], SPECIAL_PREFIX);
    assign normal_cand[i] = !empty[i] && !spec_head[i];
    assign push[i]        = (st_q == IN_IDLE) && core_req[i] && (!full[i] || pop[i]);
    assign core_ack[i]    = ack_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q  <= IN_IDLE;
        ack_q <= 1'b0;
      end else begin
        case (st_q)
          IN_IDLE: if (push[i]) begin
            st_q  <= IN_ACK;
            ack_q <= 1'b1;
          end
          IN_ACK: if (!core_req[i]) begin
            st_q  <= IN_IDLE;
            ack_q <= 1'b0;
          end
          default: begin
            st_q  <= IN_IDLE;
            ack_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign all_special = &spec_head;

  // First normal candidate at or after the round-robin pointer.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx_w = '0;
    for (int k = 0; k < CORE_NUM; k++) begin
      idx_w = {1'b0, rr_q} + (CIW+1)'(k);
      if (idx_w >= (CIW+1)'(CORE_NUM)) idx_w = idx_w - (CIW+1)'(CORE_NUM);
      if (!found && normal_cand[idx_w[CIW-1:0]]) begin
        found = 1'b1;
        sel   = idx_w[CIW-1:0];
      end
    end
  end

  always_comb begin
    pop = '0;
    if (out_state_q == OUT_REQ && evt_ack) begin
      pop = merge_q ? {CORE_NUM{1'b1}} : (CORE_NUM'(1) << gnt_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_state_q <= OUT_IDLE;
      req_q       <= 1'b0;
      addr_q      <= '0;
      rr_q        <= '0;
      gnt_q       <= '0;
      merge_q     <= 1'b0;
    end else begin
      case (out_state_q)
        OUT_IDLE: begin
          if (all_special) begin
            addr_q      <= {CIW'(0), head[0]};
            merge_q     <= 1'b1;
            req_q       <= 1'b1;
            out_state_q <= OUT_REQ;
          end else if (found) begin
            addr_q      <= {sel, head[sel]};
            gnt_q       <= sel;
            merge_q     <= 1'b0;
            req_q       <= 1'b1;
            out_state_q <= OUT_REQ;
          end
        end
        OUT_REQ: begin
          if (evt_ack) begin
            req_q       <= 1'b0;
            out_state_q <= OUT_WAIT_LOW;
            // A barrier event does not consume a round-robin turn.
            if (!merge_q) begin
              rr_q <= (gnt_q == CIW'(CORE_NUM-1)) ? '0 : gnt_q + CIW'(1);
            end
          end
        end
        OUT_WAIT_LOW: begin
          if (!evt_ack) out_state_q <= OUT_IDLE;
        end
        default: out_state_q <= OUT_IDLE;
      endcase
    end
  end

  assign evt_req         = req_q;
  assign evt_addr        = addr_q;
  assign fifo_full       = full;
  assign special_pending = spec_head;

endmodule

`default_nettype wire

// File: tb/tb_aer_multicore_event_merger.sv
// ============================================================================
// tb_aer_multicore_event_merger : scoreboard bench for the AER event merger
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_aer_multicore_event_merger;

  logic        clk;
  logic        rst;
  logic [3:0]  req_a;
  logic [7:0]  addr_a [4];
  logic        use0;
  logic        ack_en;

  logic [3:0]  core_req1,  core_req0;
  logic [31:0] core_addr1, core_addr0;
  logic [3:0]  core_ack1,  core_ack0;
  logic        evt_req1,   evt_req0;
  logic [9:0]  evt_addr1,  evt_addr0;
  logic        evt_ack1,   evt_ack0;
  logic [3:0]  full1,      full0;
  logic [3:0]  sp1,        sp0;
  logic [3:0]  cur_ack;

  logic [9:0]  exp_q  [$];
  logic [9:0]  exp0_q [$];
  int          n_cmp;
  int          n_err;

  aer_multicore_event_merger #(
    .CORE_NUM(4), .AER_OUT_CORE_WIDTH(8), .FIFO_DEPTH(4),
    .SPECIAL_PREFIX(2'b01), .MERGE_SPECIAL(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .core_req(core_req1), .core_addr(core_addr1),
    .core_ack(core_ack1), .evt_req(evt_req1), .evt_addr(evt_addr1),
    .evt_ack(evt_ack1), .fifo_full(full1), .special_pending(sp1)
  );

  aer_multicore_event_merger #(
    .CORE_NUM(4), .AER_OUT_CORE_WIDTH(8), .FIFO_DEPTH(4),
    .SPECIAL_PREFIX(2'b01), .MERGE_SPECIAL(1'b0)
  ) dut0 (
    .clk(clk), .rst(rst), .core_req(core_req0), .core_addr(core_addr0),
    .core_ack(core_ack0), .evt_req(evt_req0), .evt_addr(evt_addr0),
    .evt_ack(evt_ack0), .fifo_full(full0), .special_pending(sp0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      core_req1[i]        = req_a[i] && !use0;
      core_req0[i]        = req_a[i] && use0;
      core_addr1[i*8 +: 8] = addr_a[i];
      core_addr0[i*8 +: 8] = addr_a[i];
    end
  end
  assign cur_ack = use0 ? core_ack0 : core_ack1;

  // Output-side responders: pop the scoreboard when an event is acknowledged.
  initial begin
    logic [9:0] e;
    evt_ack1 = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        evt_ack1 = 1'b0;
      end else if (!evt_ack1 && evt_req1 && ack_en) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_evt: evt_addr=%h, none required", evt_addr1);
        end else begin
          e = exp_q.pop_front();
          if (evt_addr1 !== e) begin
            n_err++;
            $display("FAIL evt_addr: got %h, required %h", evt_addr1, e);
          end
        end
        evt_ack1 = 1'b1;
      end else if (evt_ack1 && !evt_req1) begin
        evt_ack1 = 1'b0;
      end
    end
  end

  initial begin
    logic [9:0] e;
    evt_ack0 = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        evt_ack0 = 1'b0;
      end else if (!evt_ack0 && evt_req0) begin
        n_cmp++;
        if (exp0_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_evt_nomerge: evt_addr=%h, none required", evt_addr0);
        end else begin
          e = exp0_q.pop_front();
          if (evt_addr0 !== e) begin
            n_err++;
            $display("FAIL evt_addr_nomerge: got %h, required %h", evt_addr0, e);
          end
        end
        evt_ack0 = 1'b1;
      end else if (evt_ack0 && !evt_req0) begin
        evt_ack0 = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send(input int c, input logic [7:0] a);
    int t;
    @(negedge clk); #1;
    addr_a[c] = a;
    req_a[c]  = 1'b1;
    t = 0;
    while (!cur_ack[c] && t < 500) begin @(negedge clk); #1; t++; end
    n_cmp++;
    if (!cur_ack[c]) begin
      n_err++;
      $display("FAIL ack_rise_timeout: core %0d core_ack=0, required 1", c);
    end
    req_a[c] = 1'b0;
    t = 0;
    while (cur_ack[c] && t < 500) begin @(negedge clk); #1; t++; end
    n_cmp++;
    if (cur_ack[c]) begin
      n_err++;
      $display("FAIL ack_fall_timeout: core %0d core_ack=1, required 0", c);
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || exp0_q.size() != 0 || evt_req1 || evt_ack1 ||
            evt_req0 || evt_ack0) && t < 400) begin
      @(negedge clk); #1; t++;
    end
    repeat (10) @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0 || exp0_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: %0d/%0d events outstanding, required 0",
               name, exp_q.size(), exp0_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (core_ack1 !== 4'h0) begin n_err++; $display("FAIL rst_core_ack: got %h, required 0", core_ack1); end
    n_cmp++; if (evt_req1 !== 1'b0)  begin n_err++; $display("FAIL rst_evt_req: got %b, required 0", evt_req1); end
    n_cmp++; if (evt_addr1 !== 10'h0) begin n_err++; $display("FAIL rst_evt_addr: got %h, required 0", evt_addr1); end
    n_cmp++; if (full1 !== 4'h0)     begin n_err++; $display("FAIL rst_fifo_full: got %h, required 0", full1); end
    n_cmp++; if (sp1 !== 4'h0)       begin n_err++; $display("FAIL rst_special_pending: got %h, required 0", sp1); end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    logic [7:0] a;
    ack_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      a = 8'(c * 8);
      exp_q.push_back({2'(c), a});
      send(c, a);
    end
    drain("sequential");
  endtask

  task automatic test_barrier();
    int t;
    ack_en = 1'b0;
    fork
      send(0, 8'h41);
      send(1, 8'h52);
      send(2, 8'h43);
      send(3, 8'h54);
    join
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (sp1 !== 4'hF)       begin n_err++; $display("FAIL barrier_pending: got %h, required f", sp1); end
    n_cmp++; if (evt_req1 !== 1'b1)  begin n_err++; $display("FAIL barrier_req: got %b, required 1", evt_req1); end
    n_cmp++; if (evt_addr1 !== 10'h041) begin n_err++; $display("FAIL barrier_addr: got %h, required 041", evt_addr1); end
    exp_q.push_back(10'h041);
    ack_en = 1'b1;
    t = 0;
    while (!evt_ack1 && t < 50) begin @(negedge clk); #1; t++; end
    @(negedge clk); #1;
    n_cmp++; if (sp1 !== 4'h0) begin n_err++; $display("FAIL barrier_pending_clear: got %h, required 0", sp1); end
    drain("barrier");
  endtask

  task automatic test_mixed();
    ack_en = 1'b1;
    exp_q.push_back(10'h107);
    exp_q.push_back(10'h107);
    fork
      begin send(0, 8'h41); send(0, 8'h05); end
      begin send(1, 8'h07); send(1, 8'h07); end
    join
    drain("mixed");
    n_cmp++; if (sp1 !== 4'b0001) begin n_err++; $display("FAIL mixed_pending: got %h, required 1", sp1); end
    exp_q.push_back(10'h041);
    exp_q.push_back(10'h005);
    fork
      send(1, 8'h40);
      send(2, 8'h40);
      send(3, 8'h40);
    join
    drain("mixed_release");
    n_cmp++; if (sp1 !== 4'h0) begin n_err++; $display("FAIL mixed_pending_clear: got %h, required 0", sp1); end
  endtask

  task automatic test_fairness();
    @(negedge clk); #1; rst = 1'b1;
    @(negedge clk); #1; rst = 1'b0;
    ack_en = 1'b0;
    fork
      begin send(0, 8'h01); send(0, 8'h02); send(0, 8'h03); end
      begin send(2, 8'h21); send(2, 8'h22); send(2, 8'h23); end
    join
    exp_q.push_back(10'h001); exp_q.push_back(10'h221);
    exp_q.push_back(10'h002); exp_q.push_back(10'h222);
    exp_q.push_back(10'h003); exp_q.push_back(10'h223);
    ack_en = 1'b1;
    drain("fairness");
  endtask

  task automatic test_backpressure();
    int sent;
    sent   = 0;
    ack_en = 1'b0;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          send(1, 8'(8'h30 + k));
          sent++;
        end
      end
    join_none
    repeat (80) @(negedge clk);
    #1;
    n_cmp++; if (sent !== 4)          begin n_err++; $display("FAIL bp_accepted: got %0d, required 4", sent); end
    n_cmp++; if (full1[1] !== 1'b1)   begin n_err++; $display("FAIL bp_fifo_full: got %b, required 1", full1[1]); end
    n_cmp++; if (core_ack1[1] !== 1'b0) begin n_err++; $display("FAIL bp_ack_withheld: got %b, required 0", core_ack1[1]); end
    for (int k = 0; k < 5; k++) exp_q.push_back({2'd1, 8'(8'h30 + k)});
    ack_en = 1'b1;
    wait fork;
    n_cmp++; if (sent !== 5) begin n_err++; $display("FAIL bp_fifth: got %0d, required 5", sent); end
    drain("backpressure");
  endtask

  task automatic test_reset_mid();
    int highs;
    ack_en = 1'b0;
    send(3, 8'h11);
    send(3, 8'h12);
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (evt_req1 !== 1'b1) begin n_err++; $display("FAIL mid_req_before: got %b, required 1", evt_req1); end
    rst = 1'b1;
    #1;
    n_cmp++; if (evt_req1 !== 1'b0)   begin n_err++; $display("FAIL mid_async_req: got %b, required 0", evt_req1); end
    n_cmp++; if (evt_addr1 !== 10'h0) begin n_err++; $display("FAIL mid_async_addr: got %h, required 0", evt_addr1); end
    @(negedge clk); #1;
    rst    = 1'b0;
    ack_en = 1'b1;
    highs  = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk); #1;
      if (evt_req1) highs++;
    end
    n_cmp++; if (highs !== 0) begin n_err++; $display("FAIL mid_no_replay: evt_req high %0d cycles, required 0", highs); end
  endtask

  task automatic test_no_merge();
    use0 = 1'b1;
    exp0_q.push_back(10'h041); exp0_q.push_back(10'h152);
    exp0_q.push_back(10'h243); exp0_q.push_back(10'h354);
    fork
      send(0, 8'h41);
      send(1, 8'h52);
      send(2, 8'h43);
      send(3, 8'h54);
    join
    drain("no_merge");
    use0 = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    req_a  = 4'h0;
    use0   = 1'b0;
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) addr_a[i] = 8'h00;
    test_reset();
    test_sequential();
    test_barrier();
    test_mixed();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_no_merge();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
